// File: rtl/bird_update_master.sv
// ============================================================================
// Module   : bird_update_master
// Brief    : Per-frame bird physics (gravity, flap, playfield clamp) and an
//            Avalon-MM write master that pushes bird Y to display registers
//            5 (low byte) and 6 (high byte).
// Options  : BIRD_HI_SKIP_EN - skip the high-byte write when it is unchanged
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_update_master #(
    parameter int Y_INIT   = 240,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 456,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int V_MAX    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              flap,
    output logic [2:0]        address,
    output logic [7:0]        writedata,
    output logic              write,
    output logic              chipselect,
    input  logic              waitrequest,
    output logic [9:0]        bird_y,
    output logic signed [7:0] velocity,
    output logic              busy,
    output logic              hit_floor,
    output logic              overrun
);

    localparam logic signed [11:0] c_y_max_s  = 12'(Y_MAX);
    localparam logic signed [11:0] c_y_min_s  = 12'(Y_MIN);
    localparam logic [9:0]         c_y_max    = 10'(Y_MAX);
    localparam logic [9:0]         c_y_min    = 10'(Y_MIN);
    localparam logic [9:0]         c_y_init   = 10'(Y_INIT);
    localparam logic signed [7:0]  c_gravity  = 8'(GRAVITY);
    localparam logic signed [7:0]  c_flap_vel = 8'(FLAP_VEL);
    localparam logic signed [7:0]  c_v_max    = 8'(V_MAX);
    localparam logic [2:0]         c_addr_lo  = 3'd5;
    localparam logic [2:0]         c_addr_hi  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_WR_LO  = 2'd2,
        S_WR_HI  = 2'd3
    } state_t;

    state_t state;
    logic   flap_d;
    logic   flap_pending;
    logic   tick_pending;
    logic   skip_hi;

    logic               flap_rise;
    logic signed [7:0]  v_grav;
    logic signed [7:0]  v_new;
    logic signed [7:0]  v_fin;
    logic signed [11:0] y_sum;
    logic [9:0]         y_new;
    logic               floor_clamp;

    assign flap_rise = flap & ~flap_d;

    always_comb begin
        v_grav      = velocity + c_gravity;
        if (v_grav > c_v_max) begin
            v_grav = c_v_max;
        end
        v_new       = flap_pending ? c_flap_vel : v_grav;
        y_sum       = $signed({2'b00, bird_y}) + 12'(v_new);
        v_fin       = v_new;
        floor_clamp = 1'b0;
        if (y_sum > c_y_max_s) begin
            y_new       = c_y_max;
            v_fin       = '0;
            floor_clamp = 1'b1;
        end else if (y_sum < c_y_min_s) begin
            y_new = c_y_min;
            v_fin = '0;
        end else begin
            y_new = y_sum[9:0];
        end
    end

`ifdef BIRD_HI_SKIP_EN
    logic       hi_valid;
    logic [1:0] last_hi;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_valid <= 1'b0;
            last_hi  <= 2'b00;
        end else if (state == S_WR_HI && !waitrequest) begin
            hi_valid <= 1'b1;
            last_hi  <= bird_y[9:8];
        end
    end

    assign skip_hi = hi_valid && (bird_y[9:8] == last_hi);
`else
    assign skip_hi = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            bird_y       <= c_y_init;
            velocity     <= '0;
            address      <= '0;
            writedata    <= '0;
            write        <= 1'b0;
            chipselect   <= 1'b0;
            busy         <= 1'b0;
            hit_floor    <= 1'b0;
            overrun      <= 1'b0;
            flap_d       <= 1'b0;
            flap_pending <= 1'b0;
            tick_pending <= 1'b0;
        end else begin
            flap_d <= flap;

            // A new rising edge in the consuming cycle re-arms the request.
            if (state == S_UPDATE) begin
                flap_pending <= flap_rise;
            end else if (flap_rise) begin
                flap_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (frame_tick || tick_pending) begin
                        state        <= S_UPDATE;
                        busy         <= 1'b1;
                        tick_pending <= 1'b0;
                        if (frame_tick && tick_pending) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                S_UPDATE: begin
                    bird_y     <= y_new;
                    velocity   <= v_fin;
                    if (floor_clamp) begin
                        hit_floor <= 1'b1;
                    end
                    address    <= c_addr_lo;
                    writedata  <= y_new[7:0];
                    write      <= 1'b1;
                    chipselect <= 1'b1;
                    state      <= S_WR_LO;
                end
                S_WR_LO: begin
                    if (!waitrequest) begin
                        if (skip_hi) begin
                            write      <= 1'b0;
                            chipselect <= 1'b0;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            address   <= c_addr_hi;
                            writedata <= {6'b000000, bird_y[9:8]};
                            state     <= S_WR_HI;
                        end
                    end
                end
                S_WR_HI: begin
                    if (!waitrequest) begin
                        write      <= 1'b0;
                        chipselect <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Ticks that land while busy queue once; a second one is lost.
            if (state != S_IDLE && frame_tick) begin
                if (tick_pending) begin
                    overrun <= 1'b1;
                end else begin
                    tick_pending <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
